layer_4_featuremap_packer: RTL and testbench

- Producer-side counterpart of the layer-4 feature-map convolution blocks.
- Accepts a channel-serial stream of 32-bit float activations (one word per cycle, channel 0 first, pixels in raster order) through a valid/ready handshake.
- Packs each pixel's NUM_CH words into one channel-parallel vector and issues it with a single-cycle valid pulse, which directly drives the featuremap data_in/valid_in inputs.
- Tracks the pixel position across an IMG_SIZE x IMG_SIZE frame and flags frame completion.

---
 rtl/layer_4_featuremap_packer.sv | 154 +++++++++++++++
 tb/tb_layer_4_featuremap_packer.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_4_featuremap_packer.sv
// Channel-serial to channel-parallel activation packer for the layer-4
// feature-map blocks; tracks pixel position and flags frame completion.
module layer_4_featuremap_packer #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH     = 32,
  parameter int IMG_SIZE   = 104
) (
  input  logic                           Clk,
  input  logic                           Rst,
  input  logic                           start,
  input  logic [DATA_WIDTH-1:0]          s_data,
  input  logic                           s_valid,
  output logic                           s_ready,
  output logic [DATA_WIDTH*NUM_CH-1:0]   data_out,
  output logic                           valid_out,
  output logic [$clog2(IMG_SIZE)-1:0]    pixel_col,
  output logic [$clog2(IMG_SIZE)-1:0]    pixel_row,
  output logic                           busy,
  output logic                           frame_done
);

  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PW = $clog2(IMG_SIZE);
  localparam logic [CW-1:0] CH_LAST  = CW'(NUM_CH - 1);
  localparam logic [PW-1:0] POS_LAST = PW'(IMG_SIZE - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  typedef logic [NUM_CH-1:0][DATA_WIDTH-1:0] acc_t;

  state_t                       state_q, state_d;
  logic [CW-1:0]                ch_q, ch_d;
  logic [PW-1:0]                col_q, col_d;
  logic [PW-1:0]                row_q, row_d;
  acc_t                         acc_q, acc_d;
  logic [DATA_WIDTH*NUM_CH-1:0] dout_q, dout_d;
  logic                         valid_q, valid_d;
  logic [PW-1:0]                pcol_q, pcol_d;
  logic [PW-1:0]                prow_q, prow_d;
  logic                         ready_q, ready_d;
  logic                         busy_q, busy_d;
  logic                         fdone_q, fdone_d;

  logic accept;
  logic last_ch;
  logic last_col;
  logic last_row;

  // ready_q is high exactly while in COLLECT, so it gates acceptance
  assign accept   = s_valid & ready_q;
  assign last_ch  = (ch_q == CH_LAST);
  assign last_col = (col_q == POS_LAST);
  assign last_row = (row_q == POS_LAST);

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    col_d   = col_q;
    row_d   = row_q;
    acc_d   = acc_q;
    dout_d  = dout_q;
    valid_d = 1'b0;
    pcol_d  = pcol_q;
    prow_d  = prow_q;
    fdone_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = COLLECT;
          ch_d    = '0;
          col_d   = '0;
          row_d   = '0;
        end
      end
      COLLECT: begin
        if (accept) begin
          acc_d[ch_q] = s_data;
          if (last_ch) begin
            ch_d    = '0;
            dout_d  = acc_d;
            valid_d = 1'b1;
            pcol_d  = col_q;
            prow_d  = row_q;
            if (last_col) begin
              col_d = '0;
              if (last_row) begin
                row_d   = '0;
                state_d = DONE;
                fdone_d = 1'b1;
              end else begin
                row_d = row_q + PW'(1);
              end
            end else begin
              col_d = col_q + PW'(1);
            end
          end else begin
            ch_d = ch_q + CW'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    ready_d = (state_d == COLLECT);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= IDLE;
      ch_q    <= '0;
      col_q   <= '0;
      row_q   <= '0;
      acc_q   <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      pcol_q  <= '0;
      prow_q  <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      fdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      col_q   <= col_d;
      row_q   <= row_d;
      acc_q   <= acc_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      pcol_q  <= pcol_d;
      prow_q  <= prow_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      fdone_q <= fdone_d;
    end
  end

  assign s_ready    = ready_q;
  assign data_out   = dout_q;
  assign valid_out  = valid_q;
  assign pixel_col  = pcol_q;
  assign pixel_row  = prow_q;
  assign busy       = busy_q;
  assign frame_done = fdone_q;

endmodule

// File: tb/tb_layer_4_featuremap_packer.sv
// Scoreboard bench: a full-size packer and a 4x4, 2-channel packer
// share clock and reset; monitors pop expected pixels on valid_out.
module tb_layer_4_featuremap_packer;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // full-size DUT
  logic          start0 = 1'b0;
  logic [31:0]   s_data0 = '0;
  logic          s_valid0 = 1'b0;
  logic          s_ready0;
  logic [1023:0] data_out0;
  logic          valid_out0;
  logic [6:0]    pixel_col0, pixel_row0;
  logic          busy0, frame_done0;

  layer_4_featuremap_packer u_dut0 (
    .Clk(Clk), .Rst(Rst), .start(start0),
    .s_data(s_data0), .s_valid(s_valid0), .s_ready(s_ready0),
    .data_out(data_out0), .valid_out(valid_out0),
    .pixel_col(pixel_col0), .pixel_row(pixel_row0),
    .busy(busy0), .frame_done(frame_done0)
  );

  // small-frame DUT
  logic        start1 = 1'b0;
  logic [31:0] s_data1 = '0;
  logic        s_valid1 = 1'b0;
  logic        s_ready1;
  logic [63:0] data_out1;
  logic        valid_out1;
  logic [1:0]  pixel_col1, pixel_row1;
  logic        busy1, frame_done1;

  layer_4_featuremap_packer #(
    .DATA_WIDTH(32), .NUM_CH(2), .IMG_SIZE(4)
  ) u_dut1 (
    .Clk(Clk), .Rst(Rst), .start(start1),
    .s_data(s_data1), .s_valid(s_valid1), .s_ready(s_ready1),
    .data_out(data_out1), .valid_out(valid_out1),
    .pixel_col(pixel_col1), .pixel_row(pixel_row1),
    .busy(busy1), .frame_done(frame_done1)
  );

  typedef struct packed {
    logic [1023:0] d;
    logic [6:0]    c;
    logic [6:0]    r;
    logic          fd;
  } exp0_t;

  typedef struct packed {
    logic [63:0] d;
    logic [1:0]  c;
    logic [1:0]  r;
    logic        fd;
  } exp1_t;

  exp0_t q0[$];
  exp1_t q1[$];

  bit chk_ready0 = 0;
  int last1 = -1;
  int done1 = -1;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor for the full-size DUT
  always @(negedge Clk) begin
    if (chk_ready0) check("ready_held", 64'(s_ready0), 64'd1);
    if (!Rst && valid_out0) begin
      exp0_t e;
      checks++;
      if (q0.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid0: got col %0d row %0d expected none",
                 pixel_col0, pixel_row0);
      end else begin
        e = q0.pop_front();
        if (data_out0 !== e.d) begin
          errors++;
          for (int k = 0; k < 32; k++)
            if (data_out0[k*32 +: 32] !== e.d[k*32 +: 32]) begin
              $display("FAIL data0 ch%0d: got %h expected %h", k,
                       data_out0[k*32 +: 32], e.d[k*32 +: 32]);
              break;
            end
        end
        check("col0", 64'(pixel_col0), 64'(e.c));
        check("row0", 64'(pixel_row0), 64'(e.r));
        check("fdone0", 64'(frame_done0), 64'(e.fd));
      end
    end
  end

  // monitor for the small DUT, including pulse spacing and frame end
  always @(negedge Clk) begin
    if (done1 >= 0 && cyc == done1 + 1)
      check("ready1_after_done", 64'(s_ready1), 64'd0);
    if (done1 >= 0 && cyc == done1 + 2)
      check("busy1_dropped", 64'(busy1), 64'd0);
    if (!Rst && valid_out1) begin
      exp1_t e;
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid1: got col %0d row %0d expected none",
                 pixel_col1, pixel_row1);
      end else begin
        e = q1.pop_front();
        if (data_out1 !== e.d) begin
          errors++;
          $display("FAIL data1: got %h expected %h", data_out1, e.d);
        end
        check("col1", 64'(pixel_col1), 64'(e.c));
        check("row1", 64'(pixel_row1), 64'(e.r));
        check("fdone1", 64'(frame_done1), 64'(e.fd));
        if (last1 >= 0) check("spacing1", 64'(cyc - last1), 64'd2);
        last1 = cyc;
        if (e.fd) begin
          check("busy1_at_done", 64'(busy1), 64'd1);
          done1 = cyc;
        end
      end
    end
  end

  task automatic push0(input logic [31:0] w);
    bit rdy;
    int n = 0;
    s_valid0 = 1'b1;
    s_data0  = w;
    do begin
      @(negedge Clk);
      rdy = s_ready0;
      @(posedge Clk);
      #1;
      n++;
    end while (!rdy && n < 200);
    if (!rdy) begin
      errors++;
      $display("FAIL push0_timeout: got ready 0 expected 1");
    end
    s_valid0 = 1'b0;
  endtask

  task automatic push1(input logic [31:0] w);
    bit rdy;
    int n = 0;
    s_valid1 = 1'b1;
    s_data1  = w;
    do begin
      @(negedge Clk);
      rdy = s_ready1;
      @(posedge Clk);
      #1;
      n++;
    end while (!rdy && n < 200);
    if (!rdy) begin
      errors++;
      $display("FAIL push1_timeout: got ready 0 expected 1");
    end
  endtask

  task automatic pulse_start0();
    @(posedge Clk);
    #1 start0 = 1'b1;
    @(posedge Clk);
    #1 start0 = 1'b0;
  endtask

  task automatic do_reset();
    #1 Rst = 1'b1;
    repeat (2) @(posedge Clk);
    #1 Rst = 1'b0;
  endtask

  function automatic logic [1023:0] pix0(input logic [31:0] base);
    logic [1023:0] v;
    for (int k = 0; k < 32; k++) v[k*32 +: 32] = base + 32'(k);
    return v;
  endfunction

  task automatic send_pix0(input logic [31:0] base);
    for (int k = 0; k < 32; k++) push0(base + 32'(k));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp0_t e0;
    exp1_t e1;
    do_reset();
    @(negedge Clk);
    check("rst_data", 64'(data_out0[63:0]), 64'd0);
    check("rst_valid", 64'(valid_out0), 64'd0);
    check("rst_ready", 64'(s_ready0), 64'd0);
    check("rst_busy", 64'(busy0), 64'd0);
    check("rst_fdone", 64'(frame_done0), 64'd0);
    check("rst_pos", 64'({pixel_col0, pixel_row0}), 64'd0);

    // single pixel, continuous input
    pulse_start0();
    e0 = '{d: pix0(32'h3F80_0000), c: 7'd0, r: 7'd0, fd: 1'b0};
    q0.push_back(e0);
    send_pix0(32'h3F80_0000);
    @(negedge Clk);
    check("latency", 64'(valid_out0), 64'd1);
    check("ch0_word", 64'(data_out0[31:0]), 64'h3F80_0000);
    check("ch31_word", 64'(data_out0[1023:992]), 64'h3F80_001F);
    @(negedge Clk);
    check("single_pulse", 64'(valid_out0), 64'd0);
    check("data_held", 64'(data_out0[31:0]), 64'h3F80_0000);

    // three pixels with random gaps
    do_reset();
    pulse_start0();
    chk_ready0 = 1;
    for (int p = 0; p < 3; p++) begin
      logic [31:0] base;
      base = 32'hA000_0000 | (32'(p) << 8);
      e0 = '{d: pix0(base), c: 7'(p), r: 7'd0, fd: 1'b0};
      q0.push_back(e0);
      for (int k = 0; k < 32; k++) begin
        repeat ($urandom_range(0, 3)) @(posedge Clk);
        #1;
        push0(base + 32'(k));
      end
    end
    repeat (2) @(posedge Clk);
    #1 chk_ready0 = 0;

    // full 4x4 frame on the small DUT
    @(posedge Clk);
    #1 start1 = 1'b1;
    @(posedge Clk);
    #1 start1 = 1'b0;
    for (int p = 0; p < 16; p++) begin
      logic [31:0] w0, w1;
      w0 = 32'h1000_0000 + 32'(p * 16);
      w1 = w0 + 32'd1;
      e1 = '{d: {w1, w0}, c: 2'(p % 4), r: 2'(p / 4), fd: (p == 15)};
      q1.push_back(e1);
    end
    for (int p = 0; p < 16; p++) begin
      push1(32'h1000_0000 + 32'(p * 16));
      push1(32'h1000_0000 + 32'(p * 16) + 32'd1);
    end
    s_valid1 = 1'b0;
    repeat (4) @(posedge Clk);
    #1;
    check("frame1_pulses", 64'(q1.size()), 64'd0);
    check("frame1_done_seen", 64'(done1 >= 0), 64'd1);

    // reset in the middle of a pixel
    do_reset();
    pulse_start0();
    for (int k = 0; k < 17; k++) push0(32'hDEAD_0000 + 32'(k));
    @(negedge Clk);
    Rst = 1'b1;
    #1;
    check("midrst_ready", 64'(s_ready0), 64'd0);
    check("midrst_busy", 64'(busy0), 64'd0);
    check("midrst_data", 64'(data_out0[63:0]), 64'd0);
    check("midrst_pos", 64'({pixel_col0, pixel_row0}), 64'd0);
    @(posedge Clk);
    #1 Rst = 1'b0;
    pulse_start0();
    e0 = '{d: pix0(32'h5500_0000), c: 7'd0, r: 7'd0, fd: 1'b0};
    q0.push_back(e0);
    send_pix0(32'h5500_0000);

    // start during COLLECT has no effect
    e0 = '{d: pix0(32'h6600_0000), c: 7'd1, r: 7'd0, fd: 1'b0};
    q0.push_back(e0);
    for (int k = 0; k < 10; k++) push0(32'h6600_0000 + 32'(k));
    start0 = 1'b1;
    push0(32'h6600_000A);
    start0 = 1'b0;
    for (int k = 11; k < 32; k++) push0(32'h6600_0000 + 32'(k));
    repeat (2) @(posedge Clk);

    // IDLE with s_valid high and no start
    do_reset();
    s_valid0 = 1'b1;
    s_data0  = 32'hFFFF_FFFF;
    for (int i = 0; i < 8; i++) begin
      @(negedge Clk);
      check("idle_ready", 64'(s_ready0), 64'd0);
    end
    s_valid0 = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    check("q0_drained", 64'(q0.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
